// File: rtl/spi_master_pkg.sv
// Shared types and default constants for the spi_master initiator.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam int WIDTH_DEFAULT   = 180;
    localparam int CLK_DIV_DEFAULT = 4;

endpackage

// File: rtl/spi_master_if.sv
// Host request/response and SPI pin bundle for spi_master.
interface spi_master_if #(
    parameter int WIDTH = spi_master_pkg::WIDTH_DEFAULT
);
    import spi_master_pkg::*;

    // Handshake: start is a one-cycle request taken only while busy=0 and done=0;
    // busy stays high from the accepting edge until done, which pulses for one cycle.
    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;
    logic             spi_cs_b;
    logic             spi_sclk;
    logic             spi_sdi;
    logic             spi_sdo;
    state_t           fsm_state;

    modport master (
        input  start, tx_data, spi_sdo,
        output busy, done, rx_data, spi_cs_b, spi_sclk, spi_sdi, fsm_state
    );

    modport slave (
        output start, tx_data, spi_sdo,
        input  busy, done, rx_data, spi_cs_b, spi_sclk, spi_sdi, fsm_state
    );

endinterface

// File: rtl/spi_clk_gen.sv
// Phase tick generator: one-cycle tick every CLK_DIV cycles while enabled.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int            DW   = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator, MSB first. Define SPI_MASTER_READBACK_EN to build the
// spi_sdo capture path; otherwise rx_data is tied to zero.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] tx_shift;
    logic [CW-1:0]    bit_cnt;
    logic             cs_b_q;
    logic             sclk_q;
    logic             busy_q;
    logic             done_q;
    logic             tick;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .tick (tick)
    );

    // spi_sdi is the shifter MSB, so it only moves on falling sclk and at the cs_b edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_shift <= '0;
            bit_cnt  <= '0;
            cs_b_q   <= 1'b1;
            sclk_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !done_q) begin
                        tx_shift <= bus.tx_data;
                        bit_cnt  <= '0;
                        cs_b_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        sclk_q <= 1'b1;
                        state  <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        sclk_q   <= 1'b0;
                        bit_cnt  <= bit_cnt + CW'(1);
                        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            state <= HOLD;
                        end else begin
                            sclk_q <= 1'b1;
                            state  <= HIGH;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_b_q   <= 1'b1;
                        tx_shift <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_MASTER_READBACK_EN
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_q;
    logic             rise;

    // Same edges that raise sclk: leaving SETUP, or leaving LOW with bits remaining.
    assign rise = tick && ((state == SETUP) || (state == LOW && bit_cnt != LAST_BIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift <= '0;
            rx_q     <= '0;
        end else begin
            if (rise) begin
                rx_shift <= {rx_shift[WIDTH-2:0], bus.spi_sdo};
            end
            if (state == HOLD && tick) begin
                rx_q <= rx_shift;
            end
        end
    end

    assign bus.rx_data = rx_q;
`else
    logic unused_sdo;
    assign unused_sdo  = bus.spi_sdo;
    assign bus.rx_data = '0;
`endif

    assign bus.spi_cs_b  = cs_b_q;
    assign bus.spi_sclk  = sclk_q;
    assign bus.spi_sdi   = tx_shift[WIDTH-1];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: two instances (CLK_DIV=4 and CLK_DIV=1) each
// talking to a behavioural shift-register chip.
module tb_spi_master;
  import spi_master_pkg::*;

  localparam int W      = 180;
  localparam int NL     = 2;
  localparam int BUDGET = 3000;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         start_v [NL];
  logic [W-1:0] tx_v    [NL];
  logic [W-1:0] pat_v   [NL];
  logic         busy_v  [NL];
  logic         done_v  [NL];
  logic         cs_v    [NL];
  logic         sclk_v  [NL];
  logic         sdi_v   [NL];
  logic [W-1:0] rx_v    [NL];
  logic [W-1:0] chip_v  [NL];
  int           rise_v  [NL];
  state_t       st_v    [NL];

  int n_checks = 0;
  int n_fail   = 0;

  int           exp_lane_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rx_q[$];

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < 6; i++) w = (w << 32) | W'($urandom());
    return w;
  endfunction

  // Behavioural chip: shifts spi_sdi in on rising sclk, presents its readback
  // pattern MSB first, changing spi_sdo on cs_b fall and on each falling sclk.
  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int D = (g == 0) ? 4 : 1;

    spi_master_if #(.WIDTH(W)) bus ();

    logic         sdo;
    logic [W-1:0] chip_reg;
    int           rise_cnt;
    int           fall_cnt;
    logic         prev_sclk;

    spi_master #(.WIDTH(W), .CLK_DIV(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
    );

    assign bus.start   = start_v[g];
    assign bus.tx_data = tx_v[g];
    assign bus.spi_sdo = sdo;
    assign busy_v[g]   = bus.busy;
    assign done_v[g]   = bus.done;
    assign cs_v[g]     = bus.spi_cs_b;
    assign sclk_v[g]   = bus.spi_sclk;
    assign sdi_v[g]    = bus.spi_sdi;
    assign rx_v[g]     = bus.rx_data;
    assign chip_v[g]   = chip_reg;
    assign rise_v[g]   = rise_cnt;
    assign st_v[g]     = bus.fsm_state;

    initial begin
      logic [W-1:0] p;
      sdo       = 1'b0;
      chip_reg  = '0;
      rise_cnt  = 0;
      fall_cnt  = 0;
      prev_sclk = 1'b0;
      forever begin
        @(posedge bus.spi_sclk or negedge bus.spi_sclk or negedge bus.spi_cs_b);
        p = pat_v[g];
        if (bus.spi_sclk !== prev_sclk) begin
          prev_sclk = bus.spi_sclk;
          if (bus.spi_sclk && !bus.spi_cs_b) begin
            chip_reg = {chip_reg[W-2:0], bus.spi_sdi};
            rise_cnt++;
          end else if (!bus.spi_sclk) begin
            fall_cnt++;
            sdo = (fall_cnt < W) ? p[W-1-fall_cnt] : 1'b0;
          end
        end else if (!bus.spi_cs_b) begin
          rise_cnt = 0;
          fall_cnt = 0;
          sdo      = p[W-1];
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every done and checks the completed frame.
  int   low_cnt   [NL];
  int   gap_cnt   [NL];
  logic done_prev [NL];
  logic cs_prev   [NL];

  initial begin
    int           ln;
    int           div;
    logic [W-1:0] etx;
    logic [W-1:0] erx;
    for (int g = 0; g < NL; g++) begin
      low_cnt[g] = 0; gap_cnt[g] = 1; done_prev[g] = 1'b0; cs_prev[g] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < NL; g++) begin
        if (rst) begin
          low_cnt[g] = 0; gap_cnt[g] = 1; done_prev[g] = 1'b0; cs_prev[g] = 1'b1;
        end else begin
          div = (g == 0) ? 4 : 1;
          if (!cs_v[g]) begin
            if (cs_prev[g]) check("cs_high_gap_before_frame", W'(gap_cnt[g] >= 1), 1);
            low_cnt[g]++;
            gap_cnt[g] = 0;
          end else begin
            gap_cnt[g]++;
          end
          if (done_v[g]) begin
            check("done_single_pulse", done_prev[g], 0);
            if (exp_lane_q.size() == 0) begin
              check("unexpected_done", 1, 0);
            end else begin
              ln  = exp_lane_q.pop_front();
              etx = exp_q.pop_front();
              erx = exp_rx_q.pop_front();
              check("done_lane", W'(g), W'(ln));
              check("chip_register", chip_v[g], etx);
              check("rx_data", rx_v[g], erx);
              check("sclk_rising_edges", W'(rise_v[g]), W);
              check("cs_low_cycles", W'(low_cnt[g]), W'((2 * W + 2) * div));
              check("done_right_after_cs_rise", {cs_prev[g], cs_v[g]}, 2'b01);
              check("busy_low_at_done", busy_v[g], 0);
              check("state_idle_at_done", st_v[g], IDLE);
            end
            low_cnt[g] = 0;
          end
          done_prev[g] = done_v[g];
          cs_prev[g]   = cs_v[g];
        end
      end
    end
  end

  task automatic check_quiet(input int g);
    check("rst_cs_b", cs_v[g], 1);
    check("rst_sclk", sclk_v[g], 0);
    check("rst_sdi", sdi_v[g], 0);
    check("rst_busy", busy_v[g], 0);
    check("rst_done", done_v[g], 0);
    check("rst_state", st_v[g], IDLE);
  endtask

  task automatic send(input int g, input logic [W-1:0] d, input logic [W-1:0] p, input bit track);
    int cyc;
    cyc = 0;
    while ((busy_v[g] || done_v[g]) && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("send_wait_idle_timeout", W'(cyc < BUDGET), 1);
    pat_v[g]   = p;
    tx_v[g]    = d;
    start_v[g] = 1'b1;
    @(posedge clk); #1;
    start_v[g] = 1'b0;
    if (track) begin
      exp_lane_q.push_back(g);
      exp_q.push_back(d);
`ifdef SPI_MASTER_READBACK_EN
      exp_rx_q.push_back(p);
`else
      exp_rx_q.push_back('0);
`endif
    end
    check("accept_cs_low", cs_v[g], 0);
    check("accept_busy", busy_v[g], 1);
    check("accept_sdi_msb", sdi_v[g], d[W-1]);
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (exp_lane_q.size() != 0 && cyc < 4 * BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_timeout", W'(exp_lane_q.size()), 0);
    exp_lane_q.delete();
    exp_q.delete();
    exp_rx_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] alt;
    logic [W-1:0] one;
    int           cyc;
    alt = {90{2'b10}};
    one = W'(1);
    for (int g = 0; g < NL; g++) begin
      start_v[g] = 1'b0; tx_v[g] = '0; pat_v[g] = '0;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NL; g++) begin
      check_quiet(g);
      check("rst_rx_data", rx_v[g], 0);
    end
    rst = 1'b0;

    // Reset pulse while idle.
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_quiet(0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Alternating write with single-bit readback pattern, CLK_DIV=4.
    send(0, alt, one, 1'b1);
    wait_drain();

    // start and tx_data toggling while busy, then start coincident with done.
    send(0, rand_word(), rand_word(), 1'b1);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(20, 150)) @(posedge clk);
      #1;
      start_v[0] = 1'b1;
      tx_v[0]    = rand_word();
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      tx_v[0]    = rand_word();
    end
    cyc = 0;
    while (!done_v[0] && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("wait_done_timeout", W'(cyc < BUDGET), 1);
    start_v[0] = 1'b1;
    tx_v[0]    = rand_word();
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check("start_on_done_ignored_busy", busy_v[0], 0);
    check("start_on_done_ignored_cs", cs_v[0], 1);
    wait_drain();

    // Back-to-back random frames: each start lands on the cycle after done.
    for (int i = 0; i < 3; i++) send(0, rand_word(), rand_word(), 1'b1);
    wait_drain();

    // Reset in the middle of the shift (bit 90), then a clean frame.
    send(0, rand_word(), rand_word(), 1'b0);
    cyc = 0;
    while (rise_v[0] < 90 && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_bit90_timeout", W'(cyc < BUDGET), 1);
    #2 rst = 1'b1;
    #1 check_quiet(0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_quiet(0);
    send(0, rand_word(), rand_word(), 1'b1);
    wait_drain();

    // CLK_DIV=1 corner.
    send(1, alt, one, 1'b1);
    for (int i = 0; i < 3; i++) send(1, rand_word(), rand_word(), 1'b1);
    wait_drain();

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_empty", W'(exp_lane_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
